// File: rtl/axis_downsizer_scheduler.sv
// axis_downsizer_scheduler: round-robin burst scheduler sharing one axis_downsizer between wide sources
module axis_downsizer_scheduler #(
  parameter int NUM_PORTS        = 4,
  parameter int AXIS_TDATA_WIDTH = 128,
  parameter int OUTS_WIDTH       = 12
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  input  logic [NUM_PORTS*16-1:0]               cfg_burst,
  input  logic [NUM_PORTS*8-1:0]                cfg_words,
  input  logic [NUM_PORTS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]                  s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                  s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic [$clog2(NUM_PORTS)-1:0]          m_axis_tid,
  output logic [15:0]                           ds_cfg_data,
  input  logic                                  ds_tvalid,
  input  logic                                  ds_tready,
  output logic                                  sts_busy
);
  localparam int IW = $clog2(NUM_PORTS);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d, pick, pick_hi, pick_lo;
  logic [7:0] cfg_q, cfg_d;
  logic [15:0] burst_q, burst_d, burst_sel;
  logic [OUTS_WIDTH-1:0] outs_q, outs_d, outs_add;
  logic found, found_hi, run, acc, dec;
  assign run           = state_q == RUN;
  assign m_axis_tvalid = run & s_axis_tvalid[grant_q];
  assign m_axis_tdata  = run ? s_axis_tdata[grant_q*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH] : '0;
  assign s_axis_tready = (run && m_axis_tready) ? NUM_PORTS'(1) << grant_q : '0;
  assign m_axis_tid    = grant_q;
  assign ds_cfg_data   = {8'h00, cfg_q};
  assign sts_busy      = state_q != IDLE;
  assign acc           = m_axis_tvalid & m_axis_tready;
  assign dec           = ds_tvalid & ds_tready;
  always_comb begin
    found    = 1'b0;
    found_hi = 1'b0;
    pick_lo  = '0;
    pick_hi  = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (s_axis_tvalid[p]) begin
        found   = 1'b1;
        pick_lo = IW'(p);
      end
      if (s_axis_tvalid[p] && p > int'(last_q)) begin
        found_hi = 1'b1;
        pick_hi  = IW'(p);
      end
    end
    pick      = found_hi ? pick_hi : pick_lo;
    burst_sel = cfg_burst[16*pick +: 16];
  end
  always_comb begin
    outs_add = acc ? OUTS_WIDTH'(cfg_q) + OUTS_WIDTH'(1) : '0;
    outs_d   = outs_q + outs_add - OUTS_WIDTH'(dec && (acc || outs_q != '0));
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cfg_d    = cfg_q;
    burst_d  = burst_q;
    if (state_q == IDLE && found) begin
      state_d = RUN;
      grant_d = pick;
      last_d  = pick;
      cfg_d   = cfg_words[8*pick +: 8];
      burst_d = burst_sel == 16'd0 ? 16'd1 : burst_sel;
    end
    if (run && acc) begin
      burst_d = burst_q - 16'd1;
      state_d = burst_q == 16'd1 ? DRAIN : RUN;
    end
    if (state_q == DRAIN && outs_q == '0)
      state_d = IDLE;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_PORTS - 1);
      cfg_q   <= '0;
      burst_q <= '0;
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cfg_q   <= cfg_d;
      burst_q <= burst_d;
      outs_q  <= outs_d;
    end
  end
endmodule

// File: tb/tb_axis_downsizer_scheduler.sv
// tb_axis_downsizer_scheduler: vector table, corner sequences and random traffic against a cycle model
module tb_axis_downsizer_scheduler;
  localparam int N = 4;
  localparam int W = 128;
  logic aclk = 1'b0;
  logic areset;
  logic [N*16-1:0] cfg_burst;
  logic [N*8-1:0] cfg_words;
  logic [N*W-1:0] s_axis_tdata;
  logic [N-1:0] s_axis_tvalid, s_axis_tready;
  logic [W-1:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tready;
  logic [1:0] m_axis_tid;
  logic [15:0] ds_cfg_data;
  logic ds_tvalid, ds_tready, sts_busy;
  bit ds_gate;
  int n_chk = 0, n_pass = 0;
  int ms, mg, ml, mc, mb, mo;
  int g_tid[$], g_cfg[$], g_idle[$], g_beats[$], g_words[$];
  int idle_cnt = 0, beat_cnt = 0, word_cnt = 0;
  logic prev_busy = 1'b0;
  typedef struct {
    logic [N-1:0] valid;
    int burst;
    int words;
    logic [19:0] tids;
  } vec_t;
  vec_t vt[4];
  axis_downsizer_scheduler dut (
    .aclk(aclk), .areset(areset), .cfg_burst(cfg_burst), .cfg_words(cfg_words),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tid(m_axis_tid), .ds_cfg_data(ds_cfg_data), .ds_tvalid(ds_tvalid),
    .ds_tready(ds_tready), .sts_busy(sts_busy)
  );
  always #5 aclk = ~aclk;
  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick();
    logic [W-1:0] e_data;
    logic [N-1:0] e_rdy;
    bit e_mv, acc, dec;
    int no, p;
    @(negedge aclk);
    e_mv   = ms == 1 && s_axis_tvalid[mg];
    e_rdy  = (ms == 1 && m_axis_tready) ? N'(1) << mg : '0;
    e_data = ms == 1 ? s_axis_tdata[mg*W +: W] : '0;
    chk("sts_busy", sts_busy, ms != 0);
    chk("m_axis_tvalid", m_axis_tvalid, e_mv);
    chk("m_axis_tid", m_axis_tid, mg);
    chk("ds_cfg_data", ds_cfg_data, mc);
    chk("s_axis_tready", s_axis_tready, e_rdy);
    chk("m_axis_tdata", m_axis_tdata, e_data);
    if (sts_busy && !prev_busy) begin
      g_tid.push_back(int'(m_axis_tid));
      g_cfg.push_back(int'(ds_cfg_data));
      g_idle.push_back(idle_cnt);
      g_beats.push_back(beat_cnt);
      g_words.push_back(word_cnt);
      beat_cnt = 0;
      word_cnt = 0;
    end
    idle_cnt = sts_busy ? 0 : idle_cnt + 1;
    if (m_axis_tvalid && m_axis_tready) beat_cnt++;
    if (ds_tvalid && ds_tready) word_cnt++;
    prev_busy = sts_busy;
    acc = e_mv && m_axis_tready;
    dec = ds_tvalid && ds_tready;
    if (areset) begin
      ms = 0; mg = 0; ml = N - 1; mc = 0; mb = 0; mo = 0;
    end else begin
      no = mo + (acc ? mc + 1 : 0) - ((dec && (mo > 0 || acc)) ? 1 : 0);
      if (ms == 0) begin
        for (int k = 1; k <= N; k++) begin
          p = (ml + k) % N;
          if (s_axis_tvalid[p]) begin
            mg = p; ml = p; ms = 1;
            mc = int'(cfg_words[p*8 +: 8]);
            mb = int'(cfg_burst[p*16 +: 16]);
            if (mb == 0) mb = 1;
            break;
          end
        end
      end else if (ms == 1) begin
        if (acc) begin
          mb--;
          if (mb == 0) ms = 2;
        end
      end else if (mo == 0) ms = 0;
      mo = no;
    end
    @(posedge aclk);
    #1;
    ds_tvalid = mo > 0 && ds_gate;
  endtask
  task automatic set_all(int burst, int words);
    for (int p = 0; p < N; p++) begin
      cfg_burst[p*16 +: 16] = 16'(burst);
      cfg_words[p*8 +: 8]   = 8'(words);
    end
  endtask
  task automatic hold_reset();
    areset = 1'b1;
    s_axis_tvalid = '0;
    tick();
    tick();
  endtask
  task automatic wait_grants(int target);
    for (int i = 0; i < 3000 && g_tid.size() < target; i++) tick();
    chk("grant_timeout", g_tid.size() >= target, 1);
  endtask
  task automatic wait_busy();
    for (int i = 0; i < 50 && !sts_busy; i++) tick();
    chk("busy_timeout", sts_busy, 1);
  endtask
  task automatic busy_len(output int n);
    n = 0;
    while (sts_busy && n < 200) begin
      n++;
      tick();
    end
  endtask
  initial begin
    int base, eff, n;
    ms = 0; mg = 0; ml = N - 1; mc = 0; mb = 0; mo = 0;
    areset = 1'b1;
    s_axis_tvalid = '0;
    m_axis_tready = 1'b1;
    ds_tready = 1'b1;
    ds_tvalid = 1'b0;
    ds_gate = 1'b1;
    set_all(1, 0);
    for (int j = 0; j < N*W/32; j++) s_axis_tdata[j*32 +: 32] = $urandom;
    @(posedge aclk);
    #1;
    tick();
    chk("reset_busy", sts_busy, 0);
    chk("reset_tid", m_axis_tid, 0);
    chk("reset_cfg", ds_cfg_data, 0);
    chk("reset_ready", s_axis_tready, 0);
    vt[0] = '{4'b1111, 1, 0, 20'h03210};
    vt[1] = '{4'b0100, 3, 3, 20'h22222};
    vt[2] = '{4'b1010, 0, 2, 20'h13131};
    vt[3] = '{4'b1001, 2, 1, 20'h03030};
    foreach (vt[v]) begin
      hold_reset();
      set_all(vt[v].burst, vt[v].words);
      eff = vt[v].burst == 0 ? 1 : vt[v].burst;
      base = g_tid.size();
      s_axis_tvalid = vt[v].valid;
      areset = 1'b0;
      wait_grants(base + 5);
      if (g_tid.size() >= base + 5)
        for (int i = 0; i < 5; i++) begin
          chk($sformatf("vec%0d_tid%0d", v, i), g_tid[base+i], vt[v].tids[4*i +: 4]);
          chk($sformatf("vec%0d_cfg%0d", v, i), g_cfg[base+i], vt[v].words);
          if (i > 0) begin
            chk($sformatf("vec%0d_idle%0d", v, i), g_idle[base+i], 1);
            chk($sformatf("vec%0d_beats%0d", v, i), g_beats[base+i], eff);
            chk($sformatf("vec%0d_words%0d", v, i), g_words[base+i], eff * (vt[v].words + 1));
          end
        end
    end
    hold_reset();
    set_all(1, 2);
    cfg_burst[16 +: 16] = 16'd2;
    cfg_words[8 +: 8] = 8'd1;
    base = g_tid.size();
    s_axis_tvalid = 4'b1010;
    ds_tready = 1'b0;
    areset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_port3_ready", s_axis_tready[3], 0);
      if (sts_busy) chk("bp_cfg", ds_cfg_data, 1);
    end
    ds_tready = 1'b1;
    wait_grants(base + 2);
    if (g_tid.size() >= base + 2) begin
      chk("bp_first_tid", g_tid[base], 1);
      chk("bp_next_tid", g_tid[base+1], 3);
      chk("bp_words", g_words[base+1], 4);
    end
    hold_reset();
    set_all(2, 3);
    s_axis_tvalid = 4'b0001;
    areset = 1'b0;
    wait_busy();
    busy_len(n);
    chk("simul_busy_len", n, 10);
    hold_reset();
    set_all(3, 1);
    base = g_tid.size();
    s_axis_tvalid = 4'b0001;
    areset = 1'b0;
    wait_busy();
    tick();
    cfg_words[7:0] = 8'd3;
    wait_grants(base + 2);
    if (g_tid.size() >= base + 2) begin
      chk("cfgchg_old", g_cfg[base], 1);
      chk("cfgchg_new", g_cfg[base+1], 3);
    end
    hold_reset();
    set_all(4, 1);
    s_axis_tvalid = 4'b0001;
    ds_tready = 1'b0;
    areset = 1'b0;
    wait_busy();
    tick();
    areset = 1'b1;
    tick();
    chk("rst_busy", sts_busy, 0);
    chk("rst_mvalid", m_axis_tvalid, 0);
    chk("rst_tid", m_axis_tid, 0);
    chk("rst_cfg", ds_cfg_data, 0);
    chk("rst_ready", s_axis_tready, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    set_all(1, 0);
    s_axis_tvalid = 4'b1111;
    ds_tready = 1'b1;
    areset = 1'b0;
    wait_busy();
    chk("rst_priority", m_axis_tid, 0);
    busy_len(n);
    chk("rst_outs_cleared", n, 3);
    hold_reset();
    areset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      s_axis_tvalid = N'($urandom);
      m_axis_tready = $urandom_range(0, 9) < 7;
      ds_tready = $urandom_range(0, 9) < 7;
      ds_gate = $urandom_range(0, 9) < 8;
      areset = $urandom_range(0, 499) == 0;
      if ($urandom_range(0, 19) == 0) begin
        n = $urandom_range(0, N - 1);
        cfg_burst[n*16 +: 16] = 16'($urandom_range(0, 3));
        cfg_words[n*8 +: 8] = 8'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0)
        for (int j = 0; j < N*W/32; j++) s_axis_tdata[j*32 +: 32] = $urandom;
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
